shift_add3: RTL and testbench

SHIFT_ADD3 -- requirements
Module: shift_add3

---
 rtl/shift_add3.sv | 73 +++++++
 tb/tb_shift_add3.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add3.sv
// 8-bit binary to 3-digit BCD converter using iterative shift-and-add-3 (double dabble),
// one shift per clock; done pulses for one cycle when bcd is updated.
module shift_add3 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  binary,
  output logic [11:0] bcd,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [19:0] work, work_nxt, adj, shifted;
  logic [2:0]  cnt, cnt_nxt;
  logic [11:0] bcd_nxt;
  logic        done_nxt;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Digit correction precedes the shift so each digit stays in 0..9 after doubling.
  assign adj     = {add3(work[19:16]), add3(work[15:12]), add3(work[11:8]), work[7:0]};
  assign shifted = {adj[18:0], 1'b0};
  assign busy    = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    bcd_nxt   = bcd;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          work_nxt  = {12'b0, binary};
          cnt_nxt   = 3'd0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        work_nxt = shifted;
        cnt_nxt  = cnt + 3'd1;
        if (cnt == 3'd7) begin
          bcd_nxt   = shifted[19:8];
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= 20'd0;
      cnt   <= 3'd0;
      bcd   <= 12'h000;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      cnt   <= cnt_nxt;
      bcd   <= bcd_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_add3.sv
// Bench for shift_add3: decimal reference model checked every cycle, plus directed
// vectors with literal expectations for latency, back-to-back, ignore-while-busy and reset abort.
module tb_shift_add3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  binary;
  logic [11:0] bcd;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  shift_add3 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
    .bcd(bcd), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a conversion takes 8 edges after acceptance, then result + done.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [11:0] m_bcd  = 12'h000;
  logic [11:0] m_pend = 12'h000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_bcd  = 12'h000;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_bcd  = m_pend;
        end
      end else if (start) begin
        m_left = 8;
        m_pend = to_bcd(int'(binary));
      end
    end
  end

  always @(negedge clk) begin
    check("model_busy", {11'b0, busy}, {11'b0, (m_left > 0)});
    check("model_done", {11'b0, done}, {11'b0, m_done});
    check("model_bcd", bcd, m_bcd);
  end

  // Launch a conversion from idle and return the number of edges until done.
  task automatic launch(input logic [7:0] b, output int n);
    binary = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic conv(input string name, input logic [7:0] b, input logic [11:0] exp);
    int n;
    launch(b, n);
    check({name, "_lat"}, 12'(n), 12'd8);
    check({name, "_bcd"}, bcd, exp);
    @(posedge clk); #1;
    check({name, "_pulse"}, {11'b0, done}, 12'd0);
  endtask

  initial begin
    int  n;
    logic seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    binary = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", bcd, 12'h000);
    check("rst_busy", {11'b0, busy}, 12'd0);
    check("rst_done", {11'b0, done}, 12'd0);
    rst_n = 1'b1;

    conv("zero", 8'h00, 12'h000);
    conv("x04", 8'h04, 12'h004);
    conv("x0c", 8'h0C, 12'h012);
    conv("xc5", 8'hC5, 12'h197);

    // Back-to-back: second start issued in the done cycle.
    launch(8'hCC, n);
    check("b2b_first", bcd, 12'h204);
    binary = 8'hFF;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_gap", 12'(n), 12'd9);
    check("b2b_second", bcd, 12'h255);
    @(posedge clk); #1;

    // Start and binary changes during a conversion are ignored.
    binary = 8'h0C;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b1;
    binary = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    n = 4;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_ign_lat", 12'(n), 12'd8);
    check("busy_ign_bcd", bcd, 12'h012);
    repeat (12) @(posedge clk);
    #1;
    check("busy_ign_idle", {11'b0, busy}, 12'd0);
    check("busy_ign_hold", bcd, 12'h012);

    // Reset in the middle of a conversion aborts it.
    binary = 8'hC5;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {11'b0, busy}, 12'd0);
    check("abort_done", {11'b0, done}, 12'd0);
    check("abort_bcd", bcd, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | done;
    end
    check("abort_no_done", {11'b0, seen}, 12'd0);

    // First start after reset release is taken on the first edge.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    conv("post_rst", 8'h63, 12'h099);

    // Start held high: conversions restart automatically.
    binary = 8'h80;
    start  = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("held_bcd", bcd, 12'h128);

    // All inputs.
    for (int i = 0; i < 256; i++) begin
      conv("exh", 8'(i), to_bcd(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
